// File: rtl/axil_cache_pkg.sv
// Shared definitions for the AXI4-Lite to cache-core front end:
// bus response codes, the data width and the control FSM state encoding.
package axil_cache_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    BRSP,
    RRSP
  } state_t;

endpackage

// File: rtl/axil_cache_frontend.sv
// AXI4-Lite slave that turns single-beat reads and writes into requests
// for a cache core. It keeps one transaction in flight at a time.
// AW, W and AR each have a one-entry holding register. A new request can
// be accepted while another is in progress.
// Optional feature: define AXIL_CACHE_RANGE_CHECK_EN to answer any address
// >= MEM_BYTES with SLVERR without involving the cache. Without it,
// addresses wrap modulo MEM_BYTES.
module axil_cache_frontend
  import axil_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_BYTES  = 4096
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  // write address channel
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  // write data channel
  input  logic [DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  // write response channel
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  // read address channel
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  // read data channel
  output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  // cache core request side
  output logic                  cache_req_valid,
  input  logic                  cache_req_ready,
  output logic                  cache_req_we,
  output logic [ADDR_WIDTH-1:0] cache_req_addr,
  output logic [DATA_WIDTH-1:0] cache_req_wdata,
  output logic [3:0]            cache_req_wstrb,
  input  logic                  cache_resp_valid,
  input  logic [DATA_WIDTH-1:0] cache_resp_rdata
);

  // Keeps the word-offset bits inside the cache space and drops the byte
  // lane, so the cache always gets a word-aligned address that wraps.
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ADDR_WIDTH'(MEM_BYTES - 4);
`ifdef AXIL_CACHE_RANGE_CHECK_EN
  // Any bit set above the cache space means the address is out of range.
  localparam logic [ADDR_WIDTH-1:0] RANGE_MASK = ~ADDR_WIDTH'(MEM_BYTES - 1);
`endif

  state_t                  state;
  logic                    ready_en;       // holds READY low until the first edge after reset
  logic                    last_was_write; // arbitration history
  logic                    aw_full, w_full, ar_full;
  logic [ADDR_WIDTH-1:0]   aw_addr, ar_addr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [3:0]              w_strb;

  logic                    wr_pend, rd_pend, pick_read, start, bypass;
  logic                    b_done, r_done;
  logic [ADDR_WIDTH-1:0]   sel_addr;

  assign S_AXI_AWREADY = ready_en & ~aw_full;
  assign S_AXI_WREADY  = ready_en & ~w_full;
  assign S_AXI_ARREADY = ready_en & ~ar_full;

  // Arbitration between pending requests and detection of completed responses.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_pend   = aw_full & w_full;
    rd_pend   = ar_full;
    pick_read = rd_pend & (~wr_pend | last_was_write);
    start     = wr_pend | rd_pend;
    sel_addr  = pick_read ? ar_addr : aw_addr;
    bypass    = 1'b0;
`ifdef AXIL_CACHE_RANGE_CHECK_EN
    bypass    = |(sel_addr & RANGE_MASK);
`endif
    b_done    = S_AXI_BVALID & S_AXI_BREADY;
    r_done    = S_AXI_RVALID & S_AXI_RREADY;
  end

  // One-entry holding registers: fill on the channel handshake, empty on the response handshake.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      // NOTE: the data registers are reset as well, so no stale value from
      // before reset can reach the cache core.
      ready_en <= 1'b0;
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      ar_full  <= 1'b0;
      aw_addr  <= '0;
      ar_addr  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples the values from before the edge.
      ready_en <= 1'b1;
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_full <= 1'b1;
        aw_addr <= S_AXI_AWADDR;
      end else if (b_done) begin
        aw_full <= 1'b0;
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end else if (b_done) begin
        w_full <= 1'b0;
      end
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        ar_full <= 1'b1;
        ar_addr <= S_AXI_ARADDR;
      end else if (r_done) begin
        ar_full <= 1'b0;
      end
    end
  end

  // Control FSM with registered cache request and bus response outputs.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state           <= IDLE;
      last_was_write  <= 1'b1;  // the read wins the first tie after reset
      cache_req_valid <= 1'b0;
      cache_req_we    <= 1'b0;
      cache_req_addr  <= '0;
      cache_req_wdata <= '0;
      cache_req_wstrb <= '0;
      S_AXI_BVALID    <= 1'b0;
      S_AXI_BRESP     <= RESP_OKAY;
      S_AXI_RVALID    <= 1'b0;
      S_AXI_RRESP     <= RESP_OKAY;
      S_AXI_RDATA     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            last_was_write <= ~pick_read;
            if (bypass) begin
              // Out-of-range access: answer directly and do not involve the cache.
              if (pick_read) begin
                state        <= RRSP;
                S_AXI_RVALID <= 1'b1;
                S_AXI_RRESP  <= RESP_SLVERR;
                S_AXI_RDATA  <= '0;
              end else begin
                state        <= BRSP;
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= RESP_SLVERR;
              end
            end else begin
              state           <= ISSUE;
              cache_req_valid <= 1'b1;
              cache_req_we    <= ~pick_read;
              cache_req_addr  <= sel_addr & WORD_MASK;
              cache_req_wdata <= pick_read ? '0 : w_data;
              cache_req_wstrb <= pick_read ? 4'h0 : w_strb;
            end
          end
        end
        ISSUE: begin
          // The request fields stay as they are until the core accepts them.
          if (cache_req_ready) begin
            cache_req_valid <= 1'b0;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (cache_resp_valid) begin
            if (cache_req_we) begin
              state        <= BRSP;
              S_AXI_BVALID <= 1'b1;
              S_AXI_BRESP  <= RESP_OKAY;
            end else begin
              state        <= RRSP;
              S_AXI_RVALID <= 1'b1;
              S_AXI_RRESP  <= RESP_OKAY;
              S_AXI_RDATA  <= cache_resp_rdata;
            end
          end
        end
        BRSP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            state        <= IDLE;
          end
        end
        RRSP: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axil_cache_frontend.md
AXIL_CACHE_FRONTEND -- requirements
Module: axil_cache_frontend

Interface
REQ-001 ADDR_WIDTH, 16, byte address width of the AXI and cache request sides.
REQ-002 MEM_BYTES, 4096, size in bytes of the cache address space; power of two.
REQ-003 ACLK  in  1  clock; all state changes on the rising edge.
REQ-004 ARESET  in  1  reset, asynchronous and active-high.
REQ-005 S_AXI_AWADDR  in  ADDR_WIDTH  write address.
REQ-006 S_AXI_AWVALID  in  1  write address valid.
REQ-007 S_AXI_AWREADY  out  1  write address ready.
REQ-008 S_AXI_WDATA  in  32  write data.
REQ-009 S_AXI_WSTRB  in  4  write byte strobes.
REQ-010 S_AXI_WVALID  in  1  write data valid.
REQ-011 S_AXI_WREADY  out  1  write data ready.
REQ-012 S_AXI_BRESP  out  2  write response code.
REQ-013 S_AXI_BVALID  out  1  write response valid.
REQ-014 S_AXI_BREADY  in  1  write response ready.
REQ-015 S_AXI_ARADDR  in  ADDR_WIDTH  read address.
REQ-016 S_AXI_ARVALID  in  1  read address valid.
REQ-017 S_AXI_ARREADY  out  1  read address ready.
REQ-018 S_AXI_RDATA  out  32  read data.
REQ-019 S_AXI_RRESP  out  2  read response code.
REQ-020 S_AXI_RVALID  out  1  read data valid.
REQ-021 S_AXI_RREADY  in  1  read data ready.
REQ-022 cache_req_valid  out  1  request to the cache core.
REQ-023 cache_req_ready  in  1  cache core accepts the request.
REQ-024 cache_req_we  out  1  1 = write, 0 = read.
REQ-025 cache_req_addr  out  ADDR_WIDTH  word-aligned byte address; bits [1:0] are 0.
REQ-026 cache_req_wdata  out  32  write data.
REQ-027 cache_req_wstrb  out  4  byte enables; 0 for reads.
REQ-028 cache_resp_valid  in  1  one-cycle completion pulse from the cache core.
REQ-029 cache_resp_rdata  in  32  read data, valid with cache_resp_valid.

Function
REQ-030 The block SHALL implement FSM states IDLE, ISSUE, WAIT, BRSP and RRSP, with at most one cache transaction outstanding.
REQ-031 The block SHALL hold AW, W and AR each in a one-entry holding register; S_AXI_xREADY is high only while that register is empty; AW and W may be accepted in either order or in the same cycle.
REQ-032 IDLE SHALL go to ISSUE when a full write (AW and W both held) or a read (AR held) is pending; if both are pending in the same cycle, the type not served last wins (read first after reset).
REQ-033 In ISSUE, cache_req_valid SHALL be 1 with all request fields stable until cache_req_ready is sampled high; the handshake moves the FSM to WAIT.
REQ-034 In WAIT, cache_resp_valid SHALL move a write to BRSP (BRESP=OKAY) and a read to RRSP (RDATA captured, RRESP=OKAY); cache_resp_valid outside WAIT is ignored.
REQ-035 BVALID/RVALID SHALL stay high with stable data until BREADY/RREADY; the handshake clears the consumed holding registers and returns the FSM to IDLE; a READY already high gives a one-cycle response.
REQ-036 With a zero-wait cache (ready=1, resp one cycle after the request handshake), RVALID/BVALID SHALL assert 3 cycles after the last address/data handshake.
REQ-037 A new AR SHALL be accepted while a write is in flight (and the reverse) but SHALL only be issued after the current transaction retires.

Reset
REQ-038 ARESET SHALL asynchronously clear the FSM to IDLE, clear all holding registers, and drive every output to 0 (READY outputs go high one cycle after release).
REQ-039 An operation cut off by reset SHALL produce no B or R response; the cache core is reset together with this block.

Configuration
REQ-040 With AXIL_CACHE_RANGE_CHECK_EN defined, an address >= MEM_BYTES SHALL bypass the cache: the FSM goes IDLE->BRSP/RRSP with SLVERR (2'b10) and RDATA=0; without the macro, addresses are taken modulo MEM_BYTES and every response is OKAY.

Structure
REQ-041 Package axil_cache_pkg SHALL hold the RESP_OKAY/RESP_SLVERR constants, the FSM state enum and the DATA_WIDTH=32 constant; no sub-module; the holding registers are written inline.

Verification
REQ-042 Four writes of 1..4 to 0x0,0x4,0x8,0xC, then reads back -> four cache writes with wstrb=4'hF; RDATA=1..4 with RRESP=OKAY.
REQ-043 W presented 5 cycles before AW at 0x10 -> exactly one cache write, to addr 0x10, with the correct data.
REQ-044 AR and a full write pending in the same IDLE cycle after reset -> read issued first, then the write.
REQ-045 cache_req_ready held low for 7 cycles, BREADY low for 4 cycles -> request fields and BVALID/BRESP stay stable throughout.
REQ-046 With the macro defined, read of 0x1000 (MEM_BYTES=4096) -> no cache_req_valid, RRESP=2'b10, RDATA=0; ARESET pulsed in WAIT -> all outputs 0, no response.
